// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the Wishbone master arbiter and its picker.
package wb_arb_pkg;

    localparam int MAX_MASTERS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A disabled timeout still gets a 1-bit counter so the flop stays declarable.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first requester after last_grant.
module wb_arb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDXW        = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDXW-1:0]        last_grant,
    output logic [NUM_MASTERS-1:0] gnt
);

    int              idx;
    logic [IDXW-1:0] sel;
    logic            found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        // Scan last_grant+1 .. last_grant+NUM_MASTERS, wrapping; the old winner is checked last.
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            sel = IDXW'(idx);
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave path between NUM_MASTERS masters,
// with a per-beat stb-without-ack timeout that returns err to the granted master.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [DATA_WIDTH-1:0]           m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [SEL_WIDTH-1:0]            s_sel_o,
    output logic [ADDR_WIDTH-1:0]           s_adr_o,
    output logic [DATA_WIDTH-1:0]           s_dat_o,
    input  logic [DATA_WIDTH-1:0]           s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    output logic                            timeout_o,
    output logic [NUM_MASTERS-1:0]          grant_o
);

    localparam int IDXW = idx_width(NUM_MASTERS);
    localparam int CNTW = cnt_width(TIMEOUT_CYCLES);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDXW-1:0]        last_q, last_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] pick;
    logic [IDXW-1:0]        gidx;
    logic                   busy;
    logic                   cyc_g;
    logic                   stb_g;
    logic                   fire;

    wb_arb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDXW        (IDXW)
    ) u_picker (
        .req        (m_cyc_i),
        .last_grant (last_q),
        .gnt        (pick)
    );

    assign busy = (state_q == BUSY);

    // grant_q is zero outside BUSY, so every mux below idles at zero without extra gating.
    always_comb begin
        cyc_g   = 1'b0;
        stb_g   = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        gidx    = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                cyc_g   = m_cyc_i[k];
                stb_g   = m_stb_i[k];
                s_we_o  = m_we_i[k];
                s_sel_o = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
                s_adr_o = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                gidx    = IDXW'(k);
            end
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign fire = busy & cyc_g & stb_g & ~s_ack_i & ~s_err_i
                        & (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign fire = 1'b0;
        end
    endgenerate

    assign s_cyc_o   = cyc_g;
    assign s_stb_o   = stb_g & ~fire;
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i}};
    assign m_err_o   = grant_q & {NUM_MASTERS{s_err_i | fire}};
    assign timeout_o = fire;
    assign grant_o   = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|m_cyc_i) begin
                    state_d = BUSY;
                    grant_d = pick;
                end
            end
            BUSY: begin
                if (!cyc_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx;
                    cnt_d   = '0;
                end else if (s_ack_i || s_err_i || fire) begin
                    cnt_d = '0;
                end else if (stb_g && (TIMEOUT_CYCLES > 0)) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDXW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: two instances (timeout 8 and timeout disabled) share stimulus,
// checked every cycle against a behavioural round-robin/timeout model plus literal expectations.
module tb_wb_master_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*SW-1:0] m_sel;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack, s_err;

    logic [DW-1:0] dat_o [2];
    logic [N-1:0]  ack_o [2];
    logic [N-1:0]  err_o [2];
    logic          scyc  [2];
    logic          sstb  [2];
    logic          swe   [2];
    logic [SW-1:0] ssel  [2];
    logic [AW-1:0] sadr  [2];
    logic [DW-1:0] sdat  [2];
    logic          tmo   [2];
    logic [N-1:0]  gnt   [2];

    wb_master_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_dat_o(dat_o[0]), .m_ack_o(ack_o[0]), .m_err_o(err_o[0]),
        .s_cyc_o(scyc[0]), .s_stb_o(sstb[0]), .s_we_o(swe[0]),
        .s_sel_o(ssel[0]), .s_adr_o(sadr[0]), .s_dat_o(sdat[0]),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
        .timeout_o(tmo[0]), .grant_o(gnt[0])
    );

    wb_master_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(0)
    ) dut_nt (
        .clk(clk), .rst_n(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_dat_o(dat_o[1]), .m_ack_o(ack_o[1]), .m_err_o(err_o[1]),
        .s_cyc_o(scyc[1]), .s_stb_o(sstb[1]), .s_we_o(swe[1]),
        .s_sel_o(ssel[1]), .s_adr_o(sadr[1]), .s_dat_o(sdat[1]),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
        .timeout_o(tmo[1]), .grant_o(gnt[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endfunction

    // Behavioural model: who owns the bus, who won last, and how many unanswered stb cycles.
    int to_lim [2] = '{8, 0};
    bit mb_busy [2];
    int mb_own  [2];
    int mb_last [2];
    int mb_wait [2];
    bit model_ok = 1'b0;

    function automatic bit model_fire(input int i);
        int g;
        if (!mb_busy[i] || to_lim[i] == 0) return 1'b0;
        g = mb_own[i];
        return m_cyc[g] && m_stb[g] && !s_ack && !s_err && (mb_wait[i] == to_lim[i] - 1);
    endfunction

    function automatic void compare_inst(input int i);
        int            g;
        bit            f;
        logic [N-1:0]  e_gnt, e_ack, e_err;
        logic          e_cyc, e_stb, e_we;
        logic [SW-1:0] e_sel;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        f = model_fire(i);
        e_gnt = '0; e_ack = '0; e_err = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_sel = '0; e_adr = '0; e_dat = '0;
        if (mb_busy[i]) begin
            g     = mb_own[i];
            e_gnt = N'(1) << g;
            e_cyc = m_cyc[g];
            e_stb = m_stb[g] && !f;
            e_we  = m_we[g];
            e_sel = m_sel[g*SW +: SW];
            e_adr = m_adr[g*AW +: AW];
            e_dat = m_dat[g*DW +: DW];
            e_ack = s_ack ? e_gnt : '0;
            e_err = (s_err || f) ? e_gnt : '0;
        end
        check($sformatf("inst%0d grant_o", i),   64'(gnt[i]),   64'(e_gnt));
        check($sformatf("inst%0d s_cyc_o", i),   64'(scyc[i]),  64'(e_cyc));
        check($sformatf("inst%0d s_stb_o", i),   64'(sstb[i]),  64'(e_stb));
        check($sformatf("inst%0d s_we_o", i),    64'(swe[i]),   64'(e_we));
        check($sformatf("inst%0d s_sel_o", i),   64'(ssel[i]),  64'(e_sel));
        check($sformatf("inst%0d s_adr_o", i),   64'(sadr[i]),  64'(e_adr));
        check($sformatf("inst%0d s_dat_o", i),   64'(sdat[i]),  64'(e_dat));
        check($sformatf("inst%0d m_dat_o", i),   64'(dat_o[i]), 64'(s_dat_i));
        check($sformatf("inst%0d m_ack_o", i),   64'(ack_o[i]), 64'(e_ack));
        check($sformatf("inst%0d m_err_o", i),   64'(err_o[i]), 64'(e_err));
        check($sformatf("inst%0d timeout_o", i), 64'(tmo[i]),   64'(f));
    endfunction

    function automatic void model_step(input int i);
        int g;
        int c;
        bit f;
        f = model_fire(i);
        if (!rst_n) begin
            mb_busy[i] = 1'b0;
            mb_last[i] = N - 1;
            mb_wait[i] = 0;
        end else if (mb_busy[i]) begin
            g = mb_own[i];
            if (!m_cyc[g]) begin
                mb_busy[i] = 1'b0;
                mb_last[i] = g;
                mb_wait[i] = 0;
            end else if (s_ack || s_err || f) begin
                mb_wait[i] = 0;
            end else if (m_stb[g] && to_lim[i] != 0) begin
                mb_wait[i]++;
            end
        end else if (|m_cyc) begin
            for (int k = 1; k <= N; k++) begin
                c = (mb_last[i] + k) % N;
                if (m_cyc[c]) begin
                    mb_own[i] = c;
                    break;
                end
            end
            mb_busy[i] = 1'b1;
            mb_wait[i] = 0;
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (model_ok) compare_inst(i);
                model_step(i);
            end
            if (!rst_n) model_ok = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_sel = '0; m_adr = '0; m_dat = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle(input int ack_pct, input int drop_div);
        for (int k = 0; k < N; k++) begin
            if (m_cyc[k]) begin
                if ($urandom_range(0, drop_div - 1) == 0) m_cyc[k] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                m_cyc[k] = 1'b1;
            end
            m_stb[k] = m_cyc[k] & ($urandom_range(0, 9) < 7);
            m_we[k]  = 1'($urandom_range(0, 1));
            m_sel[k*SW +: SW] = SW'($urandom());
            m_adr[k*AW +: AW] = AW'($urandom());
            m_dat[k*DW +: DW] = DW'($urandom());
        end
        s_ack   = ($urandom_range(0, 99) < ack_pct);
        s_err   = ($urandom_range(0, 99) < 3);
        s_dat_i = DW'($urandom());
        rst_n   = ($urandom_range(0, 299) != 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Single write from M0, slave acks two cycles after stb is first seen.
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_sel = 8'h0F;
        m_adr[31:0] = 32'h3000_0004; m_dat[31:0] = 32'hDEAD_BEEF;
        @(negedge clk); check("t1 s_cyc latency", 64'(scyc[0]), 64'd0);
        tick();
        @(negedge clk);
        check("t1 s_cyc", 64'(scyc[0]), 64'd1);
        check("t1 grant", 64'(gnt[0]), 64'd1);
        check("t1 s_adr", 64'(sadr[0]), 64'h3000_0004);
        check("t1 s_dat", 64'(sdat[0]), 64'hDEAD_BEEF);
        tick();
        @(negedge clk); check("t1 no early ack", 64'(ack_o[0]), 64'd0);
        tick(); s_ack = 1'b1;
        @(negedge clk); check("t1 ack", 64'(ack_o[0]), 64'b01);
        tick(); s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
        @(negedge clk);
        check("t1 ack one cycle", 64'(ack_o[0]), 64'd0);
        check("t1 grant in release", 64'(gnt[0]), 64'b01);
        tick();
        @(negedge clk); check("t1 grant idle", 64'(gnt[0]), 64'd0);

        // Simultaneous requests: M0 first after reset, then M1 after one idle cycle, then M0.
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        @(negedge clk); check("t2 first grant", 64'(gnt[0]), 64'b01);
        tick(); m_cyc = 2'b10;
        @(negedge clk); check("t2 release cycle", 64'(gnt[0]), 64'b01);
        tick();
        @(negedge clk); check("t2 idle gap", 64'(gnt[0]), 64'd0);
        tick();
        @(negedge clk); check("t2 second grant", 64'(gnt[0]), 64'b10);
        tick(); m_cyc = 2'b00; m_stb = 2'b00;
        tick(); m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        @(negedge clk); check("t2 third grant", 64'(gnt[0]), 64'b01);
        tick(); idle_inputs();
        tick();

        // M1 four-beat read burst while M0 waits.
        do_reset();
        m_cyc = 2'b10;
        tick(); m_cyc = 2'b11; m_stb = 2'b10;
        for (int b = 1; b <= 4; b++) begin
            s_ack = 1'b1; s_dat_i = DW'(b);
            @(negedge clk);
            check($sformatf("t3 beat%0d ack", b), 64'(ack_o[0]), 64'b10);
            check($sformatf("t3 beat%0d err", b), 64'(err_o[0]), 64'd0);
            check($sformatf("t3 beat%0d data", b), 64'(dat_o[0]), 64'(b));
            tick();
        end
        m_cyc = 2'b01; m_stb = 2'b00; s_ack = 1'b0;
        @(negedge clk); check("t3 release", 64'(gnt[0]), 64'b10);
        tick();
        @(negedge clk); check("t3 idle gap", 64'(gnt[0]), 64'd0);
        tick();
        @(negedge clk); check("t3 M0 granted", 64'(gnt[0]), 64'b01);
        tick(); idle_inputs();
        tick();

        // Timeout fires on the 8th unanswered stb; on the next 8th, ack arrives and wins.
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick();
        for (int c = 1; c <= 16; c++) begin
            s_ack = (c == 16);
            @(negedge clk);
            if (c == 8) begin
                check("t4 err", 64'(err_o[0]), 64'b01);
                check("t4 timeout_o", 64'(tmo[0]), 64'd1);
                check("t4 stb gated", 64'(sstb[0]), 64'd0);
                check("t4 no-timeout err", 64'(err_o[1]), 64'd0);
                check("t4 no-timeout stb", 64'(sstb[1]), 64'd1);
            end else if (c == 16) begin
                check("t5 ack wins", 64'(ack_o[0]), 64'b01);
                check("t5 no err", 64'(err_o[0]), 64'd0);
                check("t5 no timeout", 64'(tmo[0]), 64'd0);
            end else begin
                check($sformatf("t4 quiet c%0d", c), 64'(tmo[0]), 64'd0);
            end
            tick();
        end
        idle_inputs();
        tick();

        // Reset mid-transfer with M1 pending.
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        tick(); m_cyc = 2'b11;
        tick(); rst_n = 1'b0; m_cyc = 2'b10; s_ack = 1'b1;
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("t6 grant after reset", 64'(gnt[0]), 64'd0);
        check("t6 s_cyc after reset", 64'(scyc[0]), 64'd0);
        check("t6 no ack", 64'(ack_o[0]), 64'd0);
        check("t6 no err", 64'(err_o[0]), 64'd0);
        tick(); s_ack = 1'b0;
        @(negedge clk); check("t6 M1 granted", 64'(gnt[0]), 64'b10);
        tick(); idle_inputs();
        tick();

        // Randomized traffic: normal ack rate, then a slow slave that provokes timeouts.
        for (int n = 0; n < 2000; n++) begin
            rand_cycle(40, 8);
            tick();
        end
        for (int n = 0; n < 2000; n++) begin
            rand_cycle(4, 40);
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Shares the single Wishbone slave path into the crypto bus splitter (AES, SHA256, PIC) between NUM_MASTERS requesters, e.g. the host port and a future DMA/job sequencer.
- Arbitration is round-robin, granted per Wishbone cycle (held while the winner's cyc stays high).
- A bus timeout returns err to the granted master if the addressed slave never acks.
- Sits directly upstream of the splitter's master port.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- SEL_WIDTH, 4, byte-select width.
- TIMEOUT_CYCLES, 255, stb-without-ack cycles before err is forced; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master we.
- m_sel_i  in  NUM_MASTERS*SEL_WIDTH  flattened sel; master k at [k*SEL_WIDTH +: SEL_WIDTH].
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened address.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  flattened write data.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  ack; only the granted bit can be 1.
- m_err_o  out  NUM_MASTERS  err; only the granted bit can be 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to splitter.
- s_sel_o  out  SEL_WIDTH.
- s_adr_o  out  ADDR_WIDTH.
- s_dat_o  out  DATA_WIDTH.
- s_dat_i  in  DATA_WIDTH.
- s_ack_i  in  1.
- s_err_i  in  1.
- timeout_o  out  1  one-cycle pulse when a timeout fires.
- grant_o  out  NUM_MASTERS  one-hot current grant; 0 when idle.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, grant_o=0, last_grant=NUM_MASTERS-1, timeout counter=0.
  - All s_* outputs, m_ack_o, m_err_o and timeout_o are 0 from that edge.
  - Reset mid-transfer abandons it silently; no ack or err is issued.
- States IDLE, BUSY.
- IDLE:
  - If any m_cyc_i is set, grant the first requester scanning last_grant+1, +2, ... modulo NUM_MASTERS. Go to BUSY next edge.
  - Arbitration latency is 1 cycle: slave-side signals appear the cycle after cyc is first seen.
- BUSY:
  - s_cyc/stb/we/sel/adr/dat are combinational muxes of the granted master.
  - s_stb_o is additionally gated low in the cycle the timeout fires.
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i | timeout_fire. Non-granted ack and err bits stay 0.
  - m_dat_o=s_dat_i, unregistered.
- Release:
  - When m_cyc_i[g]=0 in BUSY (even with stb still high), go to IDLE next edge with last_grant=g and grant_o=0.
  - One mandatory idle cycle follows, so no back-to-back grant in the release cycle.
  - Other requesters waiting during BUSY are serviced in round-robin order afterwards.
- Timeout counter:
  - Increments each BUSY cycle with s_stb_o=1 and no s_ack_i or s_err_i. Clears on ack, err, release or cyc low.
  - When count==TIMEOUT_CYCLES-1 and there is no ack or err that cycle, timeout_fire=1 for one cycle: m_err_o[g]=1, timeout_o=1, s_stb_o=0, then the counter clears.
  - If ack arrives in the same cycle the timeout would fire, ack wins and there is no err.
  - Counter width is clog2(TIMEOUT_CYCLES+1). TIMEOUT_CYCLES=0 means the counter is held at 0 and never fires.
- Pipelined bursts: multiple stb/ack pairs inside one cyc are allowed. The grant persists and the counter restarts per beat.
- Single requester: re-granted after each one-cycle idle gap; no starvation under any pattern.

Decomposition:
- Package wb_arb_pkg: state enum {IDLE, BUSY}, NUM_MASTERS max constant, clog2-based width helpers.
- One sub-module: wb_arb_rr_picker.
  - Combinational, one-hot output from req vector and last_grant.
  - Reusable by the later job sequencer.
- Timeout counter and muxes stay in the top.

Test Plan:
- M0 writes 0xDEADBEEF to 0x3000_0004, slave acks 2 cycles after stb -> s_cyc_o rises 1 cycle after m_cyc_i[0]; m_ack_o=2'b01 for exactly one cycle; s_dat_o=0xDEADBEEF; grant_o=0 one cycle after M0 drops cyc.
- M0 and M1 assert cyc in the same cycle after reset -> M0 granted first (last_grant=1 at reset). After M0 releases: one idle cycle, then M1 granted. A repeat simultaneous request then grants M0.
- M1 holds cyc through a 4-beat read burst (acks with data 1,2,3,4) while M0 is requesting -> M1 receives all 4 acks and data; m_ack_o[0] and m_err_o[0] stay 0; M0 is granted only after M1 releases.
- TIMEOUT_CYCLES=8, slave never acks -> after 8 stb cycles m_err_o[g]=1 and timeout_o=1 for one cycle, s_stb_o=0 that cycle. With TIMEOUT_CYCLES=0 the bus hangs with no err.
- Ack driven in the exact firing cycle with TIMEOUT_CYCLES=8 -> ack delivered, m_err_o=0, timeout_o=0.
- rst_n=0 for one cycle mid-burst with M0 granted -> next cycle grant_o=0, s_cyc_o=0, no ack or err. A pending M1 request is granted 1 cycle after rst_n returns high.
